// File: rtl/sd_cmd_response_rx_pkg.sv
// Shared constants and state encoding for the SD CMD response receiver
// and its serial CRC7 helper.
package sd_cmd_response_rx_pkg;

  localparam int RESP_LEN_DEFAULT = 48;        // response frame length in bits
  localparam int TIMEOUT_DEFAULT  = 64;        // Ncr: cycles allowed before the start bit
  localparam int CNT_W_DEFAULT    = 7;         // width of timeout and bit counters
  localparam logic [6:0] CRC7_POLY = 7'h09;    // x^7 + x^3 + 1, x^7 term implicit

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECEIVE    = 2'd2,
    ST_CHECK      = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sd_cmd_response_rx_crc7.sv
// Serial CRC7 (poly x^7+x^3+1, init 0), one bit per enabled clock, MSB first.
// Shared with the command transmitter.
module sd_crc7
  import sd_cmd_response_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       feedback;

  // Next CRC value: clear has priority, otherwise shift in one bit when enabled.
  always_comb begin
    crc_d    = crc_q;
    feedback = bit_in ^ crc_q[6];
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

  // CRC register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: waits for the card's start bit after a
// command, deserialises a 48-bit response and checks CRC7, end bit and index.
//
// Handshake: start_receive is a one-cycle request accepted only in IDLE
// (busy=0); the result is reported by a one-cycle response_valid strobe (or a
// one-cycle timeout_error strobe) with no back-pressure. abort takes priority
// over everything, including a simultaneous start_receive.
module sd_cmd_response_rx
  import sd_cmd_response_rx_pkg::*;
#(
  parameter int RESP_LEN = RESP_LEN_DEFAULT,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start_receive,
  input  logic                abort,
  input  logic                crc_check_en,
  input  logic                index_check_en,
  input  logic [5:0]          expected_index,
  input  logic                cmd_in,
  output logic [RESP_LEN-1:0] response_out,
  output logic                response_valid,
  output logic                crc_error,
  output logic                end_bit_error,
  output logic                index_error,
  output logic                timeout_error,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Last bit position that still feeds the CRC: bits 47..8 are covered.
  localparam logic [CNT_W-1:0] CRC_LAST_CNT = CNT_W'(RESP_LEN - 8);
  localparam logic [CNT_W-1:0] BIT_LAST_CNT = CNT_W'(RESP_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST_CNT = CNT_W'(TIMEOUT - 1);

  rx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RESP_LEN-1:0] shift_q, shift_d;
  logic [RESP_LEN-1:0] response_q, response_d;
  logic                response_valid_q, response_valid_d;
  logic                crc_error_q, crc_error_d;
  logic                end_bit_error_q, end_bit_error_d;
  logic                index_error_q, index_error_d;
  logic                timeout_error_q, timeout_error_d;

  logic                crc_clear;
  logic                crc_enable;
  logic [6:0]          crc_value;

  sd_crc7 u_crc7 (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (crc_clear),
    .enable (crc_enable),
    .bit_in (cmd_in),
    .crc    (crc_value)
  );

  // Next-state, datapath and status computation for the receive FSM.
  always_comb begin
    state_d          = state_q;
    timeout_cnt_d    = timeout_cnt_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    response_d       = response_q;
    response_valid_d = 1'b0;
    timeout_error_d  = 1'b0;
    crc_error_d      = crc_error_q;
    end_bit_error_d  = end_bit_error_q;
    index_error_d    = index_error_q;
    crc_clear        = 1'b0;
    crc_enable       = 1'b0;

    if (abort) begin
      // Drop whatever is in flight; reported outputs stay as they were.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_receive) begin
            state_d         = ST_WAIT_START;
            timeout_cnt_d   = '0;
            bit_cnt_d       = '0;
            shift_d         = '0;
            response_d      = '0;
            crc_error_d     = 1'b0;
            end_bit_error_d = 1'b0;
            index_error_d   = 1'b0;
            crc_clear       = 1'b1;
          end
        end

        ST_WAIT_START: begin
          if (!cmd_in) begin
            // Start bit: it is frame bit 47 and is part of the CRC coverage.
            shift_d    = {shift_q[RESP_LEN-2:0], cmd_in};
            bit_cnt_d  = CNT_W'(1);
            crc_enable = 1'b1;
            state_d    = ST_RECEIVE;
          end else if (timeout_cnt_q == TMO_LAST_CNT) begin
            timeout_error_d = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
          end
        end

        ST_RECEIVE: begin
          shift_d    = {shift_q[RESP_LEN-2:0], cmd_in};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          crc_enable = (bit_cnt_q < CRC_LAST_CNT);
          if (bit_cnt_q == BIT_LAST_CNT) begin
            state_d = ST_CHECK;
          end
        end

        ST_CHECK: begin
          response_d       = shift_q;
          response_valid_d = 1'b1;
          crc_error_d      = crc_check_en & (crc_value != shift_q[7:1]);
          end_bit_error_d  = ~shift_q[0];
          index_error_d    = index_check_en &
                             ((shift_q[45:40] != expected_index) | shift_q[46]);
          state_d          = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q          <= ST_IDLE;
      timeout_cnt_q    <= '0;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      response_q       <= '0;
      response_valid_q <= 1'b0;
      crc_error_q      <= 1'b0;
      end_bit_error_q  <= 1'b0;
      index_error_q    <= 1'b0;
      timeout_error_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      timeout_cnt_q    <= timeout_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      response_q       <= response_d;
      response_valid_q <= response_valid_d;
      crc_error_q      <= crc_error_d;
      end_bit_error_q  <= end_bit_error_d;
      index_error_q    <= index_error_d;
      timeout_error_q  <= timeout_error_d;
    end
  end

  assign response_out   = response_q;
  assign response_valid = response_valid_q;
  assign crc_error      = crc_error_q;
  assign end_bit_error  = end_bit_error_q;
  assign index_error    = index_error_q;
  assign timeout_error  = timeout_error_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Self-checking bench for sd_cmd_response_rx: directed frames from the test
// plan, a timeout run, reset/abort mid-frame and randomized frames scored
// against a polynomial-division CRC7 reference model.
module tb_sd_cmd_response_rx;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start_receive = 1'b0;
  logic        abort = 1'b0;
  logic        crc_check_en = 1'b0;
  logic        index_check_en = 1'b0;
  logic [5:0]  expected_index = 6'd0;
  logic        cmd_in = 1'b1;
  logic [47:0] response_out;
  logic        response_valid;
  logic        crc_error;
  logic        end_bit_error;
  logic        index_error;
  logic        timeout_error;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 CLK = ~CLK;

  sd_cmd_response_rx dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .start_receive  (start_receive),
    .abort          (abort),
    .crc_check_en   (crc_check_en),
    .index_check_en (index_check_en),
    .expected_index (expected_index),
    .cmd_in         (cmd_in),
    .response_out   (response_out),
    .response_valid (response_valid),
    .crc_error      (crc_error),
    .end_bit_error  (end_bit_error),
    .index_error    (index_error),
    .timeout_error  (timeout_error),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] exp_q[$];
  logic [2:0]  exp_flags_q[$];   // {crc_error, end_bit_error, index_error}

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Remainder of (frame[47:8] * x^7) divided by x^7+x^3+1, by long division.
  function automatic logic [6:0] model_crc(input logic [47:0] fr);
    logic [46:0] r;
    r = {fr[47:8], 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [2:0] model_flags(input logic [47:0] fr, input logic ce,
                                             input logic ie, input logic [5:0] idx);
    logic c, e, x;
    c = ce && (model_crc(fr) != fr[7:1]);
    e = !fr[0];
    x = ie && ((fr[45:40] != idx) || fr[46]);
    return {c, e, x};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_rx(input logic ce, input logic ie, input logic [5:0] idx);
    @(negedge CLK);
    crc_check_en   = ce;
    index_check_en = ie;
    expected_index = idx;
    start_receive  = 1'b1;
    @(negedge CLK);
    start_receive  = 1'b0;
  endtask

  task automatic run_frame(input logic [47:0] fr, input logic ce, input logic ie,
                           input logic [5:0] idx, input int idle, input logic [2:0] exp_flags);
    int early;
    logic [47:0] exp_resp;
    logic [2:0]  exp_f;
    early = 0;
    exp_q.push_back(fr);
    exp_flags_q.push_back(exp_flags);
    start_rx(ce, ie, idx);
    check("busy_after_start", 48'(busy), 48'd1);
    check("flags_cleared_on_start", 48'({crc_error, end_bit_error, index_error}), 48'd0);
    cmd_in = 1'b1;
    repeat (idle) begin
      @(negedge CLK);
      if (response_valid) early++;
    end
    for (int i = 47; i >= 0; i--) begin
      cmd_in = fr[i];
      @(negedge CLK);
      if (response_valid) early++;
    end
    cmd_in = 1'b1;
    check("no_early_valid", 48'(early), 48'd0);
    @(negedge CLK);
    check("valid_one_cycle_after_end_bit", 48'(response_valid), 48'd1);
    check("sb_depth", 48'(exp_q.size()), 48'd1);
    exp_resp = exp_q.pop_front();
    exp_f    = exp_flags_q.pop_front();
    check("response_out", response_out, exp_resp);
    check("crc_error", 48'(crc_error), 48'(exp_f[2]));
    check("end_bit_error", 48'(end_bit_error), 48'(exp_f[1]));
    check("index_error", 48'(index_error), 48'(exp_f[0]));
    check("busy_after_check", 48'(busy), 48'd0);
    @(negedge CLK);
    check("valid_is_pulse", 48'(response_valid), 48'd0);
    check("flags_hold", 48'({crc_error, end_bit_error, index_error}), 48'(exp_f));
  endtask

  // Arms the receiver and drives frame bits 47 down to last_bit+1.
  task automatic drive_partial(input logic [47:0] fr, input int last_bit);
    start_rx(1'b1, 1'b1, 6'd8);
    cmd_in = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 47; i > last_bit; i--) begin
      cmd_in = fr[i];
      @(negedge CLK);
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [47:0] R7_OK   = 48'h0800_0001_AA13;
  localparam logic [47:0] R7_BAD  = 48'h0800_0001_AA15;
  localparam logic [47:0] R3      = 48'h3F00_FF80_00FF;
  localparam logic [47:0] R7_NOEB = 48'h0800_0001_AA12;

  initial begin
    logic [47:0] fr;
    logic [6:0]  crc;
    logic [5:0]  idx;
    logic        ce, ie;
    int          seen_valid, seen_tmo;

    // reset state
    #3;
    check("reset_outputs",
          48'({response_valid, crc_error, end_bit_error, index_error, timeout_error, busy}), 48'd0);
    check("reset_response_out", response_out, 48'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // 1. valid R7
    run_frame(R7_OK, 1'b1, 1'b1, 6'd8, 5, 3'b000);
    // 2. bad CRC, then index mismatch
    run_frame(R7_BAD, 1'b1, 1'b1, 6'd8, 5, 3'b100);
    run_frame(R7_OK, 1'b1, 1'b1, 6'd17, 2, 3'b001);
    // 3. R3 without and with CRC check
    run_frame(R3, 1'b0, 1'b0, 6'd8, 0, 3'b000);
    run_frame(R3, 1'b1, 1'b0, 6'd8, 7, 3'b100);
    // 5. end-bit error
    run_frame(R7_NOEB, 1'b1, 1'b1, 6'd8, 1, 3'b010);

    // 4. timeout: strobe after the 64th edge following start_receive
    start_rx(1'b1, 1'b1, 6'd8);
    cmd_in = 1'b1;
    seen_valid = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge CLK);
      if (response_valid) seen_valid++;
      if (k >= 62) begin
        check($sformatf("timeout_strobe_k%0d", k), 48'(timeout_error), 48'(k == 64));
        check($sformatf("timeout_busy_k%0d", k), 48'(busy), 48'(k < 64));
      end
    end
    check("timeout_no_valid", 48'(seen_valid), 48'd0);
    run_frame(R7_OK, 1'b1, 1'b1, 6'd8, 5, 3'b000);

    // 6a. asynchronous reset after bit 20 of a frame
    drive_partial(R7_OK, 20);
    cmd_in = R7_OK[20];
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("reset_mid_frame_flags",
          48'({response_valid, crc_error, end_bit_error, index_error, timeout_error, busy}), 48'd0);
    check("reset_mid_frame_resp", response_out, 48'd0);
    @(negedge CLK);
    RESET = 1'b1;
    cmd_in = 1'b1;
    run_frame(R7_OK, 1'b1, 1'b1, 6'd8, 5, 3'b000);

    // 6b. abort at bit 30
    drive_partial(R7_OK, 30);
    cmd_in = R7_OK[30];
    abort  = 1'b1;
    @(negedge CLK);
    abort  = 1'b0;
    check("abort_busy", 48'(busy), 48'd0);
    cmd_in = 1'b1;
    seen_valid = 0;
    seen_tmo = 0;
    repeat (70) begin
      @(negedge CLK);
      if (response_valid) seen_valid++;
      if (timeout_error) seen_tmo++;
    end
    check("abort_no_strobe", 48'({seen_valid[15:0], seen_tmo[15:0]}), 48'd0);
    run_frame(R7_OK, 1'b1, 1'b1, 6'd8, 5, 3'b000);

    // abort wins over a simultaneous start_receive
    @(negedge CLK);
    start_receive = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    start_receive = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", 48'(busy), 48'd0);

    // randomized frames against the reference model
    for (int n = 0; n < 24; n++) begin
      idx = 6'($urandom_range(0, 63));
      ce  = ($urandom_range(0, 3) != 0);
      ie  = ($urandom_range(0, 3) != 0);
      fr  = '0;
      fr[46]    = ($urandom_range(0, 7) == 0);
      fr[45:40] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : idx;
      fr[39:8]  = 32'($urandom);
      crc       = model_crc(fr);
      fr[7:1]   = ($urandom_range(0, 3) == 0) ? (crc ^ 7'($urandom_range(1, 127))) : crc;
      fr[0]     = ($urandom_range(0, 4) != 0);
      run_frame(fr, ce, ie, idx, $urandom_range(0, 40), model_flags(fr, ce, ie, idx));
    end

    check("sb_empty_at_end", 48'(exp_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_response_rx.md
Name: sd_cmd_response_rx

Overview:
Receive path for the SD CMD line. After the command transmitter finishes, this block waits for the card's start bit and deserialises a 48-bit response (R1/R3/R6/R7). It checks CRC7, end bit and command index, then hands the word plus error flags to the host command FSM. It sits between the card-side CMD pin (driven by the card's parallel_to_serial) and the host register/interrupt logic, and runs in the card clock domain.

Parameters:
RESP_LEN, 48, response frame length in bits
TIMEOUT, 64, maximum card-clock cycles from start_receive to start bit (Ncr)
CNT_W, 7, width of the timeout and bit counters

Ports:
CLK  in  1  card clock; all sampling is on the rising edge
RESET  in  1  asynchronous, active-low reset
start_receive  in  1  one-cycle pulse from the cmd FSM that arms the receiver
abort  in  1  synchronous abort; return to IDLE without reporting
crc_check_en  in  1  enable the CRC7 check (0 for R3)
index_check_en  in  1  enable the index compare (0 for R2/R3)
expected_index  in  6  command index expected in bits [45:40]
cmd_in  in  1  serial CMD line, idle high
response_out  out  48  captured frame, MSB = start bit
response_valid  out  1  one-cycle completion strobe
crc_error  out  1  CRC7 mismatch
end_bit_error  out  1  bit 0 was not 1
index_error  out  1  index or transmission-bit mismatch
timeout_error  out  1  one-cycle strobe: no start bit within TIMEOUT
busy  out  1  state != IDLE

Behaviour:
- Reset (RESET=0, async): all outputs 0, state IDLE, counters and CRC cleared.
- IDLE: start_receive=1 → WAIT_START; clear the timeout counter, CRC register and error flags. start_receive while busy is ignored.
- WAIT_START: cmd_in=1 → timeout_cnt+1.
  - When timeout_cnt reaches TIMEOUT-1 with cmd_in still 1: timeout_error=1 for that cycle's successor, then IDLE. The strobe appears at cycle TIMEOUT after start_receive.
  - cmd_in=0 → the start bit is shifted in, bit_cnt=1, CRC updated, → RECEIVE.
- RECEIVE: each cycle, shift cmd_in into the LSB of the shift register and increment bit_cnt.
  - The CRC7 (poly x^7+x^3+1, init 0) is fed with bits 47..8 only, i.e. while bit_cnt<40.
  - The cycle that samples bit 0 (bit_cnt=47) → CHECK.
- CHECK (single cycle):
  - response_out <= shift register.
  - response_valid=1.
  - crc_error = crc_check_en & (crc != frame[7:1]).
  - end_bit_error = ~frame[0].
  - index_error = index_check_en & ((frame[45:40] != expected_index) | frame[46]).
  - Then → IDLE.
  - Latency: response_valid is asserted exactly 1 cycle after the end bit is sampled.
- Holding rules:
  - response_out and the three check flags hold until the next accepted start_receive or reset.
  - response_valid and timeout_error are single-cycle pulses.
- abort=1 in any state → IDLE next cycle; no strobe; outputs unchanged.
- abort and start_receive in the same cycle: abort wins.
- A mid-frame glitch is not detected. Exactly 48 bits are always consumed once the start bit is seen.
- busy is asserted from the cycle after start_receive through the CHECK cycle.

Decomposition:
- Shared defines file (defines.v) holds:
  - state encodings: IDLE, WAIT_START, RECEIVE, CHECK;
  - CRC7 polynomial 7'h09;
  - response length 48;
  - default Ncr timeout 64.
- One sub-module: sd_crc7. It is a serial CRC7 with inputs CLK, RESET, clear, enable and bit_in, and a 7-bit crc output. It is reused by the command transmitter.

Test Plan:
1. Valid R7. Set expected_index=8, both checks enabled, pulse start_receive. After 5 idle-high cycles, drive 48'h0800_0001_AA13 MSB first. → response_valid pulses once, 1 cycle after bit 0; response_out=48'h080000_01AA13; all error flags 0.
2. Same frame with last byte 8'h15 (bad CRC). → crc_error=1, other flags 0, response_out=48'h0800_0001_AA15. Repeat with expected_index=17 and a correct frame → index_error=1 only.
3. R3 frame 48'h3F00_FF80_00FF with crc_check_en=0 and index_check_en=0. → response_valid, no errors. Repeat with crc_check_en=1 → crc_error=1.
4. Timeout. Hold cmd_in=1 after start_receive. → timeout_error pulses at cycle 64, response_valid never asserts, busy drops the same cycle, and the next start_receive is accepted.
5. End-bit error. Frame 48'h0800_0001_AA12 → end_bit_error=1, crc_error=0.
6. Reset and abort mid-frame:
   - Drive RESET=0 at bit 20 of a frame → all outputs 0 immediately, state IDLE.
   - abort at bit 30 → busy=0 next cycle, no strobe.
   - In both cases a following valid frame (scenario 1) is received correctly.
